inv_stim_checker: RTL and testbench

Clocked self-checking stimulus/capture stage for the switch-level CMOS inverter cell. It drives the inverter input `x` through a fixed vector sequence and reads the inverter output `y` back after a hold window. It counts vectors where `y` is not the logical complement of `x`, then reports pass/fail. It sits directly around the inverter: upstream as the driver of `x`, downstream as the consumer of `y`. This lets the gate lab run as a synthesizable-style clocked test instead of a hand-written `#delay` bench.

---
 rtl/inv_stim_checker.sv | 160 ++++++++++++++++
 tb/tb_inv_stim_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inv_stim_checker.sv
// Clocked stimulus/capture stage around a CMOS inverter: drives a vector sequence,
// checks that each response is the complement, and reports pass/fail. Optional LFSR source: INV_CHK_LFSR_EN.
module inv_stim_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inv_out,
    output logic             inv_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned VIDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(NUM_VECTORS - 1);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VIDX_W-1:0] vidx_q, vidx_d;
    logic              inv_in_q, inv_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  vec_q, vec_d;

    logic vec0_c;
    logic vec_next_c;
    logic mismatch_c;

`ifdef INV_CHK_LFSR_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] lfsr_next_c;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    assign lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign vec0_c      = LFSR_SEED[0];
    assign vec_next_c  = lfsr_next_c[0];
`else
    assign vec0_c      = 1'b0;
    assign vec_next_c  = ~inv_in_q;
`endif

    // X or Z on the response never equals the expected complement
    assign mismatch_c = ((inv_out ^ inv_in_q) !== 1'b1);

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        vidx_d   = vidx_q;
        inv_in_d = inv_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        vec_d    = vec_q;
`ifdef INV_CHK_LFSR_EN
        lfsr_d   = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    hold_d   = '0;
                    vidx_d   = '0;
                    inv_in_d = vec0_c;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    vec_d    = '0;
`ifdef INV_CHK_LFSR_EN
                    lfsr_d   = LFSR_SEED;
`endif
                end
            end
            ST_DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    vec_d  = vec_q + CNT_W'(1);
                    if (mismatch_c && (err_q != {CNT_W{1'b1}})) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (vidx_q == VIDX_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vidx_d   = vidx_q + VIDX_W'(1);
                        inv_in_d = vec_next_c;
`ifdef INV_CHK_LFSR_EN
                        lfsr_d   = lfsr_next_c;
`endif
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            vidx_q   <= '0;
            inv_in_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            vec_q    <= '0;
`ifdef INV_CHK_LFSR_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            vidx_q   <= vidx_d;
            inv_in_q <= inv_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
`ifdef INV_CHK_LFSR_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    assign inv_in    = inv_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_count = vec_q;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Scoreboard bench for inv_stim_checker: a modelled inverter (good / stuck-0 / buffer)
// plus a narrow-counter instance fed by a buffer to exercise saturation.
module tb_inv_stim_checker;

    localparam int H = 4;
    localparam int N = 16;

    typedef struct {
        int err;
        int vec;
        int pss;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    int         mode;
    logic       y;
    logic       inv_in, busy, done, pass;
    logic [7:0] err_count, vec_count;
    logic       s_inv_in, s_busy, s_done, s_pass;
    logic [2:0] s_err, s_vec;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Inverter model: 0 good, 1 stuck at 0, 2 buffer
    always_comb begin
        y = ~inv_in;
        if (mode == 1) y = 1'b0;
        else if (mode == 2) y = inv_in;
    end

    inv_stim_checker #(.HOLD_CYCLES(H), .NUM_VECTORS(N), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inv_out(y),
        .inv_in(inv_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count)
    );

    inv_stim_checker #(.HOLD_CYCLES(H), .NUM_VECTORS(N), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .inv_out(s_inv_in),
        .inv_in(s_inv_in), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .vec_count(s_vec)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_vec(input int k);
`ifdef INV_CHK_LFSR_EN
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l[0];
`else
        return k[0];
`endif
    endfunction

    function automatic int exp_err(input int m);
        int e;
        e = 0;
        for (int k = 0; k < N; k++) begin
            if (m == 2) e++;
            else if (m == 1 && exp_vec(k) == 1'b0) e++;
        end
        return e;
    endfunction

    task automatic push_exp(input int m, input int cyc);
        exp_t e;
        e.err = exp_err(m);
        e.vec = N;
        e.pss = (e.err == 0) ? 1 : 0;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // One run (or two back-to-back with start held); c counts edges after the accepting edge
    task automatic run_one(input string tag, input int m, input bit repulse, input bit hold_start);
        int   c;
        exp_t e;
        mode = m;
        push_exp(m, N * H);
        if (hold_start) push_exp(m, 2 * N * H + 2);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        c = 0;
        check_eq({tag, "_busy0"}, 32'(busy), 32'd1);
        check_eq({tag, "_err0"}, 32'(err_count), 32'd0);
        check_eq({tag, "_vec0"}, 32'(vec_count), 32'd0);
        check_eq({tag, "_pass0"}, 32'(pass), 32'd0);
        while (sb.size() != 0 && c < 400) begin
            if (c < N * H && (c % H) == 0)
                check_eq($sformatf("%s_vin%0d", tag, c / H), 32'(inv_in), 32'(exp_vec(c / H)));
            if (done) begin
                e = sb.pop_front();
                check_eq({tag, "_cyc"}, 32'(c), 32'(e.cyc));
                check_eq({tag, "_err"}, 32'(err_count), 32'(e.err));
                check_eq({tag, "_vec"}, 32'(vec_count), 32'(e.vec));
                check_eq({tag, "_pass"}, 32'(pass), 32'(e.pss));
                check_eq({tag, "_busy"}, 32'(busy), 32'd0);
                check_eq({tag, "_sdone"}, 32'(s_done), 32'd1);
                check_eq({tag, "_serr"}, 32'(s_err), 32'd7);
                check_eq({tag, "_spass"}, 32'(s_pass), 32'd0);
                if (sb.size() == 0) start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
            if (repulse && c == 10) start = 1'b1;
            if (repulse && c == 11) start = 1'b0;
        end
        if (sb.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        start = 1'b0;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold_vin"}, 32'(inv_in), 32'(exp_vec(N - 1)));
        repeat (2) @(posedge clk);
    endtask

    task automatic run_abort();
        int seen;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_inv_in", 32'(inv_in), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_pass", 32'(pass), 32'd0);
        check_eq("abort_err", 32'(err_count), 32'd0);
        check_eq("abort_vec", 32'(vec_count), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_inv_in", 32'(inv_in), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        check_eq("rst_vec", 32'(vec_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        run_one("good", 0, 1'b0, 1'b0);
        run_one("tie0", 1, 1'b0, 1'b0);
        run_one("buf", 2, 1'b0, 1'b0);
        run_one("repulse", 0, 1'b1, 1'b0);
        run_abort();
        run_one("post_abort", 0, 1'b0, 1'b0);
        run_one("held", 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
